// File: rtl/fifo_write_arbiter.sv
// fifo_write_arbiter: round-robin burst arbiter sharing one FIFO write port among NUM_REQ requesters
module fifo_write_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 32,
  parameter int BURST_MAX  = 4
) (
  input  logic                          clock_in,
  input  logic                          rst_in_n,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  input  logic [NUM_REQ-1:0]            req_valid,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic [DATA_WIDTH-1:0]         fifo_data,
  output logic                          fifo_valid,
  input  logic                          fifo_full,
  output logic [$clog2(NUM_REQ)-1:0]    grant_id,
  output logic                          grant_active
);
  localparam int IW = $clog2(NUM_REQ);
  localparam int CW = $clog2(BURST_MAX + 1);
  localparam logic [CW-1:0] LAST_BEAT = CW'(BURST_MAX - 1);
  typedef enum logic {IDLE, GRANT} state_t;
  state_t state, state_n;
  logic [IW-1:0] grant_n, last_owner, last_n, win, idx;
  logic [CW-1:0] cnt, cnt_n;
  logic owner_valid, xfer, rel, arb, found;
  assign grant_active = state == GRANT;
  assign owner_valid  = req_valid[grant_id];
  assign xfer         = grant_active && owner_valid && !fifo_full;
  assign rel          = grant_active && ((xfer && cnt == LAST_BEAT) || !owner_valid);
  assign arb          = !grant_active || rel;
  assign fifo_data    = grant_active ? req_data[grant_id*DATA_WIDTH +: DATA_WIDTH] : '0;
  assign fifo_valid   = grant_active && owner_valid;
  assign req_ready    = grant_active ? NUM_REQ'(!fifo_full) << grant_id : '0;
  always_comb begin
    found = 1'b0;
    win   = '0;
    idx   = '0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      idx = IW'((int'(last_owner) + k) % NUM_REQ);
      if (req_valid[idx]) begin
        found = 1'b1;
        win   = idx;
      end
    end
  end
  always_comb begin
    state_n = arb ? (found ? GRANT : IDLE) : state;
    grant_n = arb && found ? win : grant_id;
    last_n  = arb && found ? win : last_owner;
    cnt_n   = arb && found ? '0 : xfer ? cnt + CW'(1) : cnt;
  end
  always_ff @(posedge clock_in or negedge rst_in_n) begin
    if (!rst_in_n) begin
      state      <= IDLE;
      grant_id   <= '0;
      last_owner <= IW'(NUM_REQ - 1);
      cnt        <= '0;
    end else begin
      state      <= state_n;
      grant_id   <= grant_n;
      last_owner <= last_n;
      cnt        <= cnt_n;
    end
  end
endmodule

// File: doc/fifo_write_arbiter.md
# fifo_write_arbiter

Round-robin arbiter that shares the write port of the asynchronous FIFO among several requesters in the write clock domain. It grants one requester at a time and holds the grant for a burst of up to BURST_MAX beats. It forwards the owner's data and valid to the FIFO and returns the FIFO's flow control as per-requester ready. It runs entirely in the FIFO write-side clock domain.

## Interface
- NUM_REQ, 4: number of requesters, 2..8
- DATA_WIDTH, 32: data width, equal to the FIFO's DATA_WIDTH
- BURST_MAX, 4: maximum beats per grant, 1..255
- clock_in  in  1  write-domain clock, rising edge
- rst_in_n  in  1  asynchronous active-low reset
- req_data  in  NUM_REQ*DATA_WIDTH  requester i's data occupies bits [i*DATA_WIDTH +: DATA_WIDTH]
- req_valid  in  NUM_REQ  per-requester data valid
- req_ready  out  NUM_REQ  per-requester beat accepted
- fifo_data  out  DATA_WIDTH  to FIFO data_in
- fifo_valid  out  1  to FIFO data_in_valid
- fifo_full  in  1  from FIFO data_in_full
- grant_id  out  clog2(NUM_REQ)  current owner index
- grant_active  out  1  a grant is held

## Operation
- **States.**
  - IDLE: grant_active=0.
  - GRANT: grant_active=1, owner = grant_id.
- **Beat transfer.** A beat transfers in a cycle when state is GRANT, req_valid[owner]=1 and fifo_full=0.
- **Datapath in GRANT (combinational from registered owner):**
  - fifo_data = owner's slice.
  - fifo_valid = req_valid[owner].
  - req_ready[owner] = !fifo_full.
  - All other req_ready = 0.
- **Datapath in IDLE:** fifo_valid=0, req_ready=0, fifo_data=0.
- **Beat counter.**
  - Width clog2(BURST_MAX+1).
  - Cleared when a new grant is taken.
  - Incremented on each transfer.
- **Release condition in GRANT**, evaluated every cycle:
  - (a) a transfer occurs while the counter equals BURST_MAX-1, or
  - (b) req_valid[owner]=0.
- **Arbitration.**
  - Happens in IDLE, and in GRANT in any cycle where the release condition holds.
  - The search starts at last_owner+1 and wraps modulo NUM_REQ.
  - The first requester with req_valid=1 wins.
  - The previous owner has lowest priority but is re-granted if it is the only requester.
  - Winner: state←GRANT, grant_id←winner, last_owner←winner, counter←0.
  - No request: state←IDLE; grant_id holds its value.
- **fifo_full handling.**
  - fifo_full never causes a release; the owner waits with the grant held.
  - There is no timeout.
- **Requester rules.**
  - A requester holds data stable while valid && !ready.
  - A requester that drops valid without a transfer loses the grant via (b).
- **Reset (asynchronous, any state).**
  - state=IDLE, grant_active=0, grant_id=0.
  - last_owner=NUM_REQ-1, so requester 0 has first priority.
  - counter=0.
  - fifo_valid=0, req_ready=0, fifo_data=0.
  - Reset mid-burst discards the grant; no partial state persists.

## Timing
- **Grant latency.** req_valid rises at edge k in IDLE → grant registered at edge k+1 → fifo_valid/req_ready valid during cycle k+1. The earliest transfer is on edge k+2.
- **Back-to-back bursts.** Release and re-arbitration occur in the same cycle. The new owner drives fifo_valid in the next cycle, so there is zero bubble between owners.
- **Burst length.** At most BURST_MAX transfers per grant. Stall cycles (fifo_full=1) do not count.
- **Full handling.** fifo_full is sampled combinationally, with no extra register stage. The FIFO's own gating (valid && !full) matches the transfer definition exactly, so no beat is lost or duplicated.
- **Outputs.** grant_id and grant_active are registered. fifo_data, fifo_valid and req_ready are combinational from registers plus req_valid/req_data/fifo_full.

## Test plan
- **Reset.** Assert rst_in_n=0 mid-burst, asynchronously between edges → grant_active, fifo_valid and req_ready all 0 immediately. After release with req_valid=4'b1111, the first grant goes to 0.
- **Round-robin.** All four requesters continuously valid, BURST_MAX=4, fifo_full=0 → grants 0,1,2,3,0… Each grant gives exactly 4 transfers, with no idle cycle between owners.
- **Early release.** Requester 2 alone sends 2 beats, then drops valid → grant released after beat 2. grant_active=0 on the following edge.
- **Full stall.** Owner 1 is mid-burst; hold fifo_full=1 for 10 cycles → req_ready[1]=0, the grant is held, and the counter is unchanged. After fifo_full falls, the remaining beats complete and the total is 4.
- **Sole requester.** Only requester 3 is valid for 12 beats → re-granted to 3 three times. fifo_valid stays continuously high and 12 transfers occur in order.
- **Scoreboard.** Random req_valid/fifo_full over 10k cycles → every beat offered appears on fifo_data exactly once, in per-requester order. No requester waits more than (NUM_REQ-1)·BURST_MAX transfers while valid and fifo_full=0.
